mole_scheduler: RTL and testbench

MOLE_SCHEDULER -- requirements
Module: mole_scheduler

---
 rtl/mole_scheduler.sv | 244 ++++++++++++++++++++++++
 tb/tb_mole_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// Whack-a-mole game scheduler: sequences gap/on phases, picks moles from the
// LFSR sample, scores keypad hits and decides the game result per mode.
module mole_scheduler #(
  parameter int UNIT        = 12_500_000,
  parameter int TIMED_UNITS = 240,
  parameter int LEVEL_STEP  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] difficulty,
  input  logic [3:0] gamemode,
  input  logic       extended,
  // LFSR sample; named rand_val because rand is a reserved word
  input  logic [3:0] rand_val,
  input  logic       hit_valid,
  input  logic [3:0] hit_idx,
  output logic [8:0] lights,
  output logic [5:0] score,
  output logic [5:0] misses,
  output logic [2:0] level,
  output logic       busy,
  output logic       game_over,
  output logic       win
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] MODE_TIMED = 4'b0010;
  localparam logic [3:0] MODE_DEATH = 4'b0100;
  localparam logic [3:0] MODE_CONT  = 4'b1000;

  localparam logic [63:0] GAME_CYC = 64'(TIMED_UNITS) * 64'(UNIT);
  localparam int GW = $clog2(GAME_CYC + 64'd1);
  localparam logic [GW-1:0] GAME_LAST = GW'(GAME_CYC - 64'd1);
  localparam int PW = $clog2(8 * UNIT + 1);
  localparam logic [5:0] STEP_LAST = 6'(LEVEL_STEP - 1);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] phase_cnt_q, phase_cnt_d;
  logic [GW-1:0] game_cnt_q, game_cnt_d;
  logic [5:0]    flick_q, flick_d;
  logic [5:0]    step_q, step_d;
  logic [3:0]    mole_q, mole_d;
  logic          have_prev_q, have_prev_d;
  logic [3:0]    mode_q, mode_d;
  logic          ext_q, ext_d;
  logic [8:0]    lights_q, lights_d;
  logic [5:0]    score_q, score_d;
  logic [5:0]    misses_q, misses_d;
  logic [2:0]    level_q, level_d;
  logic          busy_q, busy_d;
  logic          game_over_q, game_over_d;
  logic          win_q, win_d;

  logic [3:0]    gap_units, on_units;
  logic [PW-1:0] gap_last, on_last;
  logic [3:0]    rand_mod, next_mole;
  logic [5:0]    flick_limit;
  logic          is_timed, is_death, is_cont;
  logic          flick_end;

  function automatic logic [2:0] decode_level(input logic [3:0] d);
    case (d)
      4'b0001: decode_level = 3'd1;
      4'b0010: decode_level = 3'd2;
      4'b0100: decode_level = 3'd3;
      4'b1000: decode_level = 3'd4;
      default: decode_level = 3'd2;
    endcase
  endfunction

  assign is_timed    = (mode_q == MODE_TIMED);
  assign is_death    = (mode_q == MODE_DEATH);
  assign is_cont     = (mode_q == MODE_CONT);
  assign flick_limit = ext_q ? 6'd50 : 6'd25;

  // level_q already holds the decoded difficulty outside Continuity mode
  always_comb begin
    gap_units = 4'd4;
    on_units  = 4'd4;
    case (level_q)
      3'd1: begin gap_units = 4'd8; on_units = 4'd8; end
      3'd2: begin gap_units = 4'd4; on_units = 4'd4; end
      3'd3: begin gap_units = 4'd2; on_units = 4'd4; end
      3'd4: begin gap_units = 4'd1; on_units = 4'd2; end
      default: begin gap_units = 4'd4; on_units = 4'd4; end
    endcase
    gap_last = PW'(gap_units) * PW'(UNIT) - PW'(1);
    on_last  = PW'(on_units) * PW'(UNIT) - PW'(1);
  end

  always_comb begin
    rand_mod = (rand_val < 4'd9) ? rand_val : rand_val - 4'd9;
    if (have_prev_q && rand_mod == mole_q) begin
      next_mole = (rand_mod == 4'd8) ? 4'd0 : rand_mod + 4'd1;
    end else begin
      next_mole = rand_mod;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    game_cnt_d  = game_cnt_q;
    flick_d     = flick_q;
    step_d      = step_q;
    mole_d      = mole_q;
    have_prev_d = have_prev_q;
    mode_d      = mode_q;
    ext_d       = ext_q;
    lights_d    = lights_q;
    score_d     = score_q;
    misses_d    = misses_q;
    level_d     = level_q;
    win_d       = win_q;
    flick_end   = 1'b0;

    case (state_q)
      S_GAP: begin
        phase_cnt_d = phase_cnt_q + PW'(1);
        if (phase_cnt_q == gap_last) begin
          phase_cnt_d = '0;
          state_d     = S_ON;
          mole_d      = next_mole;
          have_prev_d = 1'b1;
          lights_d    = 9'b1 << next_mole;
        end
      end
      S_ON: begin
        phase_cnt_d = phase_cnt_q + PW'(1);
        // A correct hit wins over expiry on the final ON cycle
        if (hit_valid && hit_idx == mole_q) begin
          score_d     = (score_q == 6'd63) ? score_q : score_q + 6'd1;
          lights_d    = '0;
          state_d     = S_GAP;
          phase_cnt_d = '0;
          flick_end   = 1'b1;
          if (is_cont) begin
            if (step_q == STEP_LAST) begin
              step_d  = '0;
              level_d = (level_q == 3'd4) ? level_q : level_q + 3'd1;
            end else begin
              step_d  = step_q + 6'd1;
            end
          end
        end else if (phase_cnt_q == on_last) begin
          misses_d    = (misses_q == 6'd63) ? misses_q : misses_q + 6'd1;
          lights_d    = '0;
          state_d     = is_death ? S_DONE : S_GAP;
          phase_cnt_d = '0;
          flick_end   = 1'b1;
        end
      end
      default: ;
    endcase

    if (flick_end) begin
      flick_d = (flick_q == 6'd63) ? flick_q : flick_q + 6'd1;
      if (!is_timed && flick_d == flick_limit) state_d = S_DONE;
    end

    // The Timed-mode clock overrides whatever phase the game is in
    if (is_timed && (state_q == S_GAP || state_q == S_ON)) begin
      game_cnt_d = game_cnt_q + GW'(1);
      if (game_cnt_q == GAME_LAST) state_d = S_DONE;
    end

    if (state_d == S_DONE && state_q != S_DONE) begin
      lights_d    = '0;
      phase_cnt_d = '0;
      win_d       = is_death ? (misses_d == 6'd0) : (score_d >= misses_d);
    end

    if (start) begin
      state_d     = S_GAP;
      phase_cnt_d = '0;
      game_cnt_d  = '0;
      flick_d     = '0;
      step_d      = '0;
      have_prev_d = 1'b0;
      mode_d      = gamemode;
      ext_d       = extended;
      lights_d    = '0;
      score_d     = '0;
      misses_d    = '0;
      level_d     = (gamemode == MODE_CONT) ? 3'd1 : decode_level(difficulty);
      win_d       = 1'b0;
    end
  end

  assign busy_d      = (state_d == S_GAP) || (state_d == S_ON);
  assign game_over_d = (state_d == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      phase_cnt_q <= '0;
      game_cnt_q  <= '0;
      flick_q     <= '0;
      step_q      <= '0;
      mole_q      <= '0;
      have_prev_q <= 1'b0;
      mode_q      <= 4'b0001;
      ext_q       <= 1'b0;
      lights_q    <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      level_q     <= 3'd1;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      game_cnt_q  <= game_cnt_d;
      flick_q     <= flick_d;
      step_q      <= step_d;
      mole_q      <= mole_d;
      have_prev_q <= have_prev_d;
      mode_q      <= mode_d;
      ext_q       <= ext_d;
      lights_q    <= lights_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      level_q     <= level_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
      win_q       <= win_d;
    end
  end

  assign lights    = lights_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign level     = level_q;
  assign busy      = busy_q;
  assign game_over = game_over_q;
  assign win       = win_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed self-checking bench for mole_scheduler with UNIT=4, TIMED_UNITS=20.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mole_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] difficulty = 4'b0001;
  logic [3:0] gamemode = 4'b0001;
  logic       extended = 1'b0;
  logic [3:0] rand_val = 4'd0;
  logic       hit_valid = 1'b0;
  logic [3:0] hit_idx = 4'd0;
  logic [8:0] lights;
  logic [5:0] score;
  logic [5:0] misses;
  logic [2:0] level;
  logic       busy;
  logic       game_over;
  logic       win;

  int errors = 0;
  int checks = 0;

  mole_scheduler #(.UNIT(4), .TIMED_UNITS(20), .LEVEL_STEP(5)) dut (
    .clk(clk), .reset(reset), .start(start), .difficulty(difficulty),
    .gamemode(gamemode), .extended(extended), .rand_val(rand_val),
    .hit_valid(hit_valid), .hit_idx(hit_idx), .lights(lights),
    .score(score), .misses(misses), .level(level), .busy(busy),
    .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse start for one cycle; returns on the falling edge after the game began
  task automatic applyStimulus(input logic [3:0] diff, input logic [3:0] mode,
                               input logic ext);
    difficulty = diff;
    gamemode   = mode;
    extended   = ext;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #12;
    checkOutput("rst_lights", 32'(lights), 32'h0);
    checkOutput("rst_score", 32'(score), 32'd0);
    checkOutput("rst_misses", 32'(misses), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_game_over", 32'(game_over), 32'd0);
    checkOutput("rst_win", 32'(win), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick(3);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_lights", 32'(lights), 32'h0);

    // Normal L1, no hits: 25 flicks of 32 gap + 32 on
    $display("[TB] normal L1 no hits");
    rand_val = 4'd3;
    applyStimulus(4'b0001, 4'b0001, 1'b0);
    checkOutput("n1_busy_t0", 32'(busy), 32'd1);
    checkOutput("n1_level", 32'(level), 32'd1);
    tick(31);
    checkOutput("n1_lights_t31", 32'(lights), 32'h0);
    tick(1);
    checkOutput("n1_lights_t32", 32'(lights), 32'h008);
    tick(32);
    checkOutput("n1_misses_t64", 32'(misses), 32'd1);
    checkOutput("n1_lights_t64", 32'(lights), 32'h0);
    tick(1535);
    checkOutput("n1_go_t1599", 32'(game_over), 32'd0);
    tick(1);
    checkOutput("n1_go_t1600", 32'(game_over), 32'd1);
    checkOutput("n1_busy_done", 32'(busy), 32'd0);
    checkOutput("n1_misses", 32'(misses), 32'd25);
    checkOutput("n1_score", 32'(score), 32'd0);
    checkOutput("n1_win", 32'(win), 32'd0);

    // L4 with hits: wrong key ignored, correct hit clears lights, mole repeat avoided
    $display("[TB] L4 hits and mole selection");
    rand_val = 4'd13;
    applyStimulus(4'b1000, 4'b0001, 1'b0);
    tick(4);
    checkOutput("h_lights_on", 32'(lights), 32'h010);
    hit_valid = 1'b1;
    hit_idx   = 4'd2;
    tick(1);
    checkOutput("h_wrong_lights", 32'(lights), 32'h010);
    checkOutput("h_wrong_score", 32'(score), 32'd0);
    hit_idx   = 4'd4;
    tick(1);
    checkOutput("h_hit_lights", 32'(lights), 32'h0);
    checkOutput("h_hit_score", 32'(score), 32'd1);
    checkOutput("h_hit_busy", 32'(busy), 32'd1);
    hit_idx   = 4'd5;
    rand_val  = 4'd4;
    tick(1);
    hit_valid = 1'b0;
    checkOutput("h_gap_ignored", 32'(score), 32'd1);
    tick(2);
    checkOutput("h_gap_dark", 32'(lights), 32'h0);
    tick(1);
    checkOutput("h_next_mole", 32'(lights), 32'h020);
    checkOutput("h_level", 32'(level), 32'd4);
    tick(7);
    hit_valid = 1'b1;
    hit_idx   = 4'd5;
    tick(1);
    hit_valid = 1'b0;
    checkOutput("h_last_cycle_score", 32'(score), 32'd2);
    checkOutput("h_last_cycle_misses", 32'(misses), 32'd0);

    // Deathmatch L2 started mid-game: first miss ends it
    $display("[TB] deathmatch L2");
    applyStimulus(4'b0010, 4'b0100, 1'b0);
    checkOutput("dm_restart_score", 32'(score), 32'd0);
    checkOutput("dm_restart_lights", 32'(lights), 32'h0);
    checkOutput("dm_level", 32'(level), 32'd2);
    tick(31);
    checkOutput("dm_go_t31", 32'(game_over), 32'd0);
    tick(1);
    checkOutput("dm_go_t32", 32'(game_over), 32'd1);
    checkOutput("dm_misses", 32'(misses), 32'd1);
    checkOutput("dm_win", 32'(win), 32'd0);
    tick(8);
    checkOutput("dm_frozen", 32'(misses), 32'd1);
    checkOutput("dm_go_hold", 32'(game_over), 32'd1);

    // Timed L4: game clock expires mid-ON at 80 cycles
    $display("[TB] timed mode");
    rand_val = 4'd0;
    applyStimulus(4'b1000, 4'b0010, 1'b0);
    tick(79);
    checkOutput("t_lights_t79", 32'(lights), 32'h001);
    checkOutput("t_busy_t79", 32'(busy), 32'd1);
    tick(1);
    checkOutput("t_go_t80", 32'(game_over), 32'd1);
    checkOutput("t_busy_t80", 32'(busy), 32'd0);
    checkOutput("t_lights_t80", 32'(lights), 32'h0);
    checkOutput("t_misses", 32'(misses), 32'd6);
    checkOutput("t_win", 32'(win), 32'd0);

    // Continuity: difficulty ignored, level advances after 5 hits
    $display("[TB] continuity mode");
    applyStimulus(4'b1000, 4'b1000, 1'b0);
    checkOutput("c_level_start", 32'(level), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick(32);
      checkOutput("c_lights", 32'(lights), 32'(9'b1 << (i % 2)));
      if (i == 4) checkOutput("c_level_before", 32'(level), 32'd1);
      hit_valid = 1'b1;
      hit_idx   = 4'(i % 2);
      tick(1);
      hit_valid = 1'b0;
    end
    checkOutput("c_score", 32'(score), 32'd5);
    checkOutput("c_level_after", 32'(level), 32'd2);

    // Normal L4, 13 hits then 12 misses: win
    $display("[TB] normal win");
    applyStimulus(4'b1000, 4'b0001, 1'b0);
    for (int i = 0; i < 25; i++) begin
      tick(4);
      if (i < 13) begin
        hit_valid = 1'b1;
        hit_idx   = 4'(i % 2);
        tick(1);
        hit_valid = 1'b0;
      end else begin
        tick(8);
      end
    end
    checkOutput("w_go", 32'(game_over), 32'd1);
    checkOutput("w_score", 32'(score), 32'd13);
    checkOutput("w_misses", 32'(misses), 32'd12);
    checkOutput("w_win", 32'(win), 32'd1);

    // Async reset in the middle of ON, then a clean restart
    $display("[TB] reset mid-ON");
    rand_val = 4'd5;
    applyStimulus(4'b0001, 4'b0001, 1'b0);
    tick(32);
    checkOutput("r_lights_on", 32'(lights), 32'h020);
    tick(2);
    #2 reset = 1'b0;
    #1;
    checkOutput("r_lights_async", 32'(lights), 32'h0);
    checkOutput("r_busy_async", 32'(busy), 32'd0);
    checkOutput("r_level_async", 32'(level), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    tick(3);
    checkOutput("r_idle_busy", 32'(busy), 32'd0);
    applyStimulus(4'b0001, 4'b0001, 1'b0);
    checkOutput("r_new_busy", 32'(busy), 32'd1);
    checkOutput("r_new_score", 32'(score), 32'd0);
    tick(32);
    checkOutput("r_new_lights", 32'(lights), 32'h020);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
